// File: rtl/scrypt_pkg.sv
// scrypt_pkg: shared receive-FSM states, UART width and command-byte constants for the Scrypt hasher
package scrypt_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam logic [7:0] CMD_ALL     = 8'h01;
  localparam logic [7:0] CMD_VERSION = 8'h02;
  localparam logic [7:0] CMD_PREV    = 8'h04;
  localparam logic [7:0] CMD_MERKLE  = 8'h08;
  localparam logic [7:0] CMD_TIME    = 8'h10;
  localparam logic [7:0] CMD_BITS    = 8'h20;
  localparam logic [7:0] CMD_TAIL    = 8'h40;
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_DONE, RX_BREAK} rxStateType;
`else
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_DONE, RX_BREAK} rxStateType;
`endif
endpackage

// File: rtl/rx_sync_edge.sv
// rx_sync_edge: 2-flop synchronizer with falling-edge pulse; resets to line-high
// ports: clk, n_rst (async, active-low), line_in (async line) -> line_sync, fall_edge
module rx_sync_edge (
  input  logic clk,
  input  logic n_rst,
  input  logic line_in,
  output logic line_sync,
  output logic fall_edge
);
  logic [1:0] sync;
  logic prev;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync <= 2'b11;
      prev <= 1'b1;
    end else begin
      sync <= {sync[0], line_in};
      prev <= sync[1];
    end
  end
  assign line_sync = sync[1];
  assign fall_edge = prev & ~sync[1];
endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART 8N1 receiver (8E1 when UART_RX_PARITY_EN is defined) delivering bytes with a notify strobe
// ports: clk, n_rst (async, active-low), serial_in (idle high) -> rx_data[7:0] (last good byte),
//        rx_notify / framing_error / parity_error (one-cycle registered pulses)
module uart_rx_frame
  import scrypt_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      serial_in,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_notify,
  output logic                      framing_error,
  output logic                      parity_error
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  rxStateType state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic line_sync, fall_edge, sample, bit_end, par_ok;
  rx_sync_edge u_sync (
    .clk      (clk),
    .n_rst    (n_rst),
    .line_in  (serial_in),
    .line_sync(line_sync),
    .fall_edge(fall_edge)
  );
  assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
  always_comb begin
    sample  = 1'b0;
    state_n = state;
    case (state)
      RX_IDLE:  state_n = fall_edge ? RX_START : RX_IDLE;
      RX_START: begin
        sample  = cnt == CW'(HALF - 1);
        state_n = !sample ? RX_START : line_sync ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        sample = bit_end;
`ifdef UART_RX_PARITY_EN
        state_n = (sample && bit_idx == 3'(UART_DATA_BITS - 1)) ? RX_PARITY : RX_DATA;
`else
        state_n = (sample && bit_idx == 3'(UART_DATA_BITS - 1)) ? RX_STOP : RX_DATA;
`endif
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        sample  = bit_end;
        state_n = sample ? RX_STOP : RX_PARITY;
      end
`endif
      RX_STOP: begin
        sample  = bit_end;
        state_n = !sample ? RX_STOP : !line_sync ? RX_BREAK : par_ok ? RX_DONE : RX_IDLE;
      end
      RX_DONE:  state_n = RX_IDLE;
      RX_BREAK: state_n = line_sync ? RX_IDLE : RX_BREAK;
      default:  state_n = RX_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= RX_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      rx_data       <= '0;
      rx_notify     <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= (sample || state_n != state) ? '0 : cnt + 1'b1;
      bit_idx       <= state != RX_DATA ? '0 : sample ? bit_idx + 1'b1 : bit_idx;
      shreg         <= (sample && state == RX_DATA) ? {line_sync, shreg[UART_DATA_BITS-1:1]} : shreg;
      rx_notify     <= state_n == RX_DONE;
      rx_data       <= state_n == RX_DONE ? shreg : rx_data;
      framing_error <= sample && state == RX_STOP && !line_sync;
    end
  end
`ifdef UART_RX_PARITY_EN
  // par_ok is latched at the parity sample so STOP can rank framing above parity
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      par_ok       <= 1'b1;
      parity_error <= 1'b0;
    end else begin
      par_ok       <= (sample && state == RX_PARITY) ? line_sync == ^shreg : par_ok;
      parity_error <= sample && state == RX_STOP && line_sync && !par_ok;
    end
  end
`else
  assign par_ok       = 1'b1;
  assign parity_error = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed and randomized frames checked against a frame-level outcome model
module tb_uart_rx_frame;
  localparam int C = 16;
  localparam int HALF = C / 2;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME = (10 + PAR) * C;
  localparam int LAT = 3 + HALF + (9 + PAR) * C;
  logic clk = 1'b0, n_rst = 1'b0, serial_in = 1'b1;
  logic [7:0] rx_data;
  logic rx_notify, framing_error, parity_error;
  int cyc = 0, n_not = 0, n_fe = 0, n_pe = 0, not_cyc = 0;
  int n_chk = 0, n_fail = 0, start_cyc = 0;
  uart_rx_frame #(.CLKS_PER_BIT(C)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .serial_in    (serial_in),
    .rx_data      (rx_data),
    .rx_notify    (rx_notify),
    .framing_error(framing_error),
    .parity_error (parity_error)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rx_notify) begin
      n_not   <= n_not + 1;
      not_cyc <= cyc;
    end
    if (framing_error) n_fe <= n_fe + 1;
    if (parity_error) n_pe <= n_pe + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic bit_out(input logic v);
    serial_in = v;
    idle(C);
  endtask
  task automatic send(input logic [7:0] b, input logic stop, input logic pflip, input int hold);
    start_cyc = cyc;
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    if (PAR == 1) bit_out(^b ^ pflip);
    bit_out(stop);
    if (!stop) idle(hold);
    serial_in = 1'b1;
  endtask
  initial begin
    int s_not, s_fe, s_pe, first_cyc;
    logic [7:0] exp_data, b;
    logic stop, pflip;
    idle(3);
    chk("reset_data", rx_data, 0);
    chk("reset_notify", rx_notify, 0);
    chk("reset_ferr", framing_error, 0);
    chk("reset_perr", parity_error, 0);
    n_rst = 1'b1;
    idle(5);
    s_not = n_not; s_fe = n_fe; s_pe = n_pe;
    send(8'h01, 1'b1, 1'b0, 0);
    idle(C);
    chk("b01_count", n_not - s_not, 1);
    chk("b01_latency", not_cyc - start_cyc, LAT);
    chk("b01_data", rx_data, 8'h01);
    chk("b01_ferr", n_fe - s_fe, 0);
    chk("b01_perr", n_pe - s_pe, 0);
    s_not = n_not;
    serial_in = 1'b0;
    idle(4);
    serial_in = 1'b1;
    idle(3 * C);
    chk("glitch_notify", n_not - s_not, 0);
    chk("glitch_data", rx_data, 8'h01);
    s_not = n_not; s_fe = n_fe;
    send(8'h3C, 1'b0, 1'b0, 40);
    chk("break_ferr", n_fe - s_fe, 1);
    chk("break_notify", n_not - s_not, 0);
    chk("break_data", rx_data, 8'h01);
    idle(20);
    send(8'h10, 1'b1, 1'b0, 0);
    idle(C);
    chk("after_break_count", n_not - s_not, 1);
    chk("after_break_data", rx_data, 8'h10);
    s_not = n_not;
    send(8'h10, 1'b1, 1'b0, 0);
    first_cyc = not_cyc;
    chk("b2b_first_data", rx_data, 8'h10);
    send(8'hA5, 1'b1, 1'b0, 0);
    idle(C);
    chk("b2b_count", n_not - s_not, 2);
    chk("b2b_spacing", not_cyc - first_cyc, FRAME);
    chk("b2b_second_data", rx_data, 8'hA5);
    s_not = n_not;
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(i[0] ? 1'b0 : 1'b1);
    serial_in = 1'b0;
    idle(HALF);
    n_rst = 1'b0;
    #1;
    chk("midrst_data", rx_data, 0);
    chk("midrst_notify", rx_notify, 0);
    chk("midrst_ferr", framing_error, 0);
    chk("midrst_perr", parity_error, 0);
    idle(HALF);
    for (int i = 5; i < 8 + PAR; i++) bit_out(i[0] ? 1'b0 : 1'b1);
    bit_out(1'b1);
    n_rst = 1'b1;
    idle(2 * C);
    chk("midrst_no55", n_not - s_not, 0);
    send(8'h02, 1'b1, 1'b0, 0);
    idle(C);
    chk("post_rst_count", n_not - s_not, 1);
    chk("post_rst_data", rx_data, 8'h02);
`ifdef UART_RX_PARITY_EN
    s_not = n_not; s_pe = n_pe;
    send(8'h07, 1'b1, 1'b1, 0);
    idle(C);
    chk("par_bad_perr", n_pe - s_pe, 1);
    chk("par_bad_notify", n_not - s_not, 0);
    chk("par_bad_data", rx_data, 8'h02);
    send(8'h07, 1'b1, 1'b0, 0);
    idle(C);
    chk("par_good_notify", n_not - s_not, 1);
    chk("par_good_data", rx_data, 8'h07);
    s_fe = n_fe; s_pe = n_pe;
    send(8'h07, 1'b0, 1'b1, 10);
    idle(C);
    chk("par_both_ferr", n_fe - s_fe, 1);
    chk("par_both_perr", n_pe - s_pe, 0);
`endif
    exp_data = rx_data;
    for (int k = 0; k < 10; k++) begin
      b = 8'($urandom);
      stop = $urandom_range(3) != 0;
      pflip = PAR == 1 ? 1'($urandom_range(1)) : 1'b0;
      s_not = n_not; s_fe = n_fe; s_pe = n_pe;
      send(b, stop, pflip, $urandom_range(30));
      idle(C);
      exp_data = (stop && !pflip) ? b : exp_data;
      chk("rand_notify", n_not - s_not, (stop && !pflip) ? 1 : 0);
      chk("rand_ferr", n_fe - s_fe, stop ? 0 : 1);
      chk("rand_perr", n_pe - s_pe, (stop && pflip) ? 1 : 0);
      chk("rand_data", rx_data, exp_data);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
